// File: rtl/seq_alu.sv
// Registered ALU with a start/busy/done handshake, sticky flags, carry chaining
// and an iterative shift-add multiply on opcode 111.
module seq_alu #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [2:0]       opc_i,
  input  logic [WIDTH-1:0] ina_i,
  input  logic [WIDTH-1:0] inb_i,
  input  logic             inc_i,
  input  logic             usec_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] w_o,
  output logic             zer_o,
  output logic             neg_o,
  output logic             cry_o,
  output logic             ovf_o
);

  localparam int HALF = WIDTH / 2;
  localparam int CW   = $clog2(WIDTH + 1);
  localparam int MSB  = WIDTH - 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] w_q, w_d;
  logic             zer_q, zer_d, neg_q, neg_d, cry_q, cry_d, ovf_q, ovf_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0] add_a, add_b;
  logic             add_cin;
  logic [WIDTH:0]   add_sum;
  logic             add_ovf;
  logic [WIDTH-1:0] alu_w;
  logic             alu_cry, alu_ovf;
  logic [WIDTH-1:0] mul_acc_nxt;

  // Opcodes 001/010/011 share one adder; only the B operand and carry-in differ.
  always_comb begin
    add_a   = ina_i;
    add_b   = '0;
    add_cin = 1'b0;
    case (opc_i)
      3'b001: add_b = WIDTH'(1);
      3'b010: begin
        add_b   = inb_i;
        add_cin = usec_i ? cry_q : inc_i;
      end
      3'b011: add_b = {inb_i[MSB], inb_i[MSB:1]};
      default: add_b = '0;
    endcase
    add_sum = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
    add_ovf = (add_a[MSB] == add_b[MSB]) && (add_sum[MSB] != add_a[MSB]);
  end

  always_comb begin
    alu_w   = '0;
    alu_cry = 1'b0;
    alu_ovf = 1'b0;
    case (opc_i)
      3'b000: begin
        alu_w   = '0 - ina_i;
        alu_cry = (ina_i == '0);
        alu_ovf = (ina_i == {1'b1, {(WIDTH-1){1'b0}}});
      end
      3'b001, 3'b010, 3'b011: begin
        alu_w   = add_sum[MSB:0];
        alu_cry = add_sum[WIDTH];
        alu_ovf = add_ovf;
      end
      3'b100: alu_w = ina_i & inb_i;
      3'b101: alu_w = ina_i | inb_i;
      3'b110: alu_w = {ina_i[HALF-1:0], inb_i[HALF-1:0]};
      default: alu_w = '0;
    endcase
  end

  assign mul_acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    w_d      = w_q;
    zer_d    = zer_q;
    neg_d    = neg_q;
    cry_d    = cry_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (opc_i == 3'b111) begin
            acc_d    = '0;
            mcand_d  = ina_i;
            mplier_d = inb_i;
            cnt_d    = CW'(WIDTH);
            state_d  = ST_MUL;
          end else begin
            w_d    = alu_w;
            zer_d  = (alu_w == '0);
            neg_d  = alu_w[MSB];
            cry_d  = alu_cry;
            ovf_d  = alu_ovf;
            done_d = 1'b1;
          end
        end
      end
      ST_MUL: begin
        acc_d    = mul_acc_nxt;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          w_d     = mul_acc_nxt;
          zer_d   = (mul_acc_nxt == '0);
          neg_d   = mul_acc_nxt[MSB];
          cry_d   = 1'b0;
          ovf_d   = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      w_q      <= '0;
      zer_q    <= 1'b0;
      neg_q    <= 1'b0;
      cry_q    <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      w_q      <= w_d;
      zer_q    <= zer_d;
      neg_q    <= neg_d;
      cry_q    <= cry_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy_o = (state_q == ST_MUL);
  assign done_o = done_q;
  assign w_o    = w_q;
  assign zer_o  = zer_q;
  assign neg_o  = neg_q;
  assign cry_o  = cry_q;
  assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (WIDTH=16): an arithmetic reference model checked
// every cycle, plus hand-computed literal expectations at key points.
module tb_seq_alu;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst, start, inc, usec;
  logic [2:0]    opc;
  logic [W-1:0]  ina, inb;
  logic          busy, done, zer, neg, cry, ovf;
  logic [W-1:0]  w;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  seq_alu #(.WIDTH(W)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .opc_i(opc),
    .ina_i(ina), .inb_i(inb), .inc_i(inc), .usec_i(usec),
    .busy_o(busy), .done_o(done), .w_o(w),
    .zer_o(zer), .neg_o(neg), .cry_o(cry), .ovf_o(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: integer arithmetic on the opcode rules, multiply as a
  // plain product released after W busy cycles.
  int m_w, m_prod, m_left;
  bit m_zer, m_neg, m_cry, m_ovf, m_done, m_busy;

  always @(posedge clk) begin
    int a, b, sa, sb, full, s, cin, bs;
    if (rst) begin
      m_w = 0; m_zer = 0; m_neg = 0; m_cry = 0; m_ovf = 0;
      m_done = 0; m_busy = 0; m_left = 0;
    end else begin
      m_done = 0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 0; m_done = 1; m_w = m_prod; m_cry = 0; m_ovf = 0;
          m_zer = (m_w == 0); m_neg = m_w[15];
        end
      end else if (start) begin
        a = int'(ina); b = int'(inb);
        sa = int'($signed(ina)); sb = int'($signed(inb));
        m_done = 1;
        case (opc)
          3'd0: begin m_w = (-a) & 'hFFFF; m_cry = (a == 0); m_ovf = (a == 'h8000); end
          3'd1: begin
            full = a + 1; m_w = full & 'hFFFF; m_cry = full[16];
            m_ovf = (sa + 1 > 32767);
          end
          3'd2: begin
            cin = usec ? int'(m_cry) : int'(inc);
            full = a + b + cin; s = sa + sb + cin;
            m_w = full & 'hFFFF; m_cry = full[16]; m_ovf = (s > 32767) || (s < -32768);
          end
          3'd3: begin
            bs = sb >>> 1;
            full = a + (bs & 'hFFFF); s = sa + bs;
            m_w = full & 'hFFFF; m_cry = full[16]; m_ovf = (s > 32767) || (s < -32768);
          end
          3'd4: begin m_w = a & b; m_cry = 0; m_ovf = 0; end
          3'd5: begin m_w = a | b; m_cry = 0; m_ovf = 0; end
          3'd6: begin m_w = ((a & 'hFF) << 8) | (b & 'hFF); m_cry = 0; m_ovf = 0; end
          default: begin
            m_done = 0; m_busy = 1; m_left = W; m_prod = (a * b) & 'hFFFF;
          end
        endcase
        if (m_done) begin m_zer = (m_w == 0); m_neg = m_w[15]; end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_done", 32'(done), 32'(m_done));
      check("model_busy", 32'(busy), 32'(m_busy));
      check("model_w",    32'(w),    32'(m_w));
      check("model_zer",  32'(zer),  32'(m_zer));
      check("model_neg",  32'(neg),  32'(m_neg));
      check("model_cry",  32'(cry),  32'(m_cry));
      check("model_ovf",  32'(ovf),  32'(m_ovf));
    end
  end

  task automatic drive(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c, input logic u);
    start = 1'b1; opc = o; ina = a; inb = b; inc = c; usec = u;
  endtask

  task automatic flags(input string tag, input logic [W-1:0] ew, input bit ez, input bit en,
                       input bit ec, input bit eo);
    check({tag, "_w"},   32'(w),   32'(ew));
    check({tag, "_zer"}, 32'(zer), 32'(ez));
    check({tag, "_neg"}, 32'(neg), 32'(en));
    check({tag, "_cry"}, 32'(cry), 32'(ec));
    check({tag, "_ovf"}, 32'(ovf), 32'(eo));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; opc = '0; ina = '0; inb = '0; inc = 1'b0; usec = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    flags("rst", 16'h0000, 0, 0, 0, 0);
    rst = 1'b0;

    // Signed overflow on add
    drive(3'b010, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    @(negedge clk); start = 1'b0;
    check("addovf_done", 32'(done), 32'd1);
    flags("addovf", 16'h8000, 0, 1, 0, 1);
    @(negedge clk);
    check("addovf_done_drop", 32'(done), 32'd0);

    // Two-word chained add, back to back
    drive(3'b010, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    @(negedge clk);
    flags("chain_lo", 16'h0000, 1, 0, 1, 0);
    drive(3'b010, 16'h0000, 16'h0000, 1'b0, 1'b1);
    @(negedge clk); start = 1'b0; usec = 1'b0;
    flags("chain_hi", 16'h0001, 0, 0, 0, 0);

    // -3 * 7 with an ignored start during the multiply
    drive(3'b111, 16'hFFFD, 16'h0007, 1'b0, 1'b0);
    for (int i = 1; i <= W; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (i == 4) drive(3'b100, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
      check("mul_busy", 32'(busy), 32'd1);
      check("mul_hold_w", 32'(w), 32'h0001);
    end
    @(negedge clk);
    check("mul_done", 32'(done), 32'd1);
    check("mul_busy_end", 32'(busy), 32'd0);
    flags("mul", 16'hFFEB, 0, 1, 0, 0);

    // Accept on the multiply's done cycle
    drive(3'b011, 16'h0010, 16'h8000, 1'b0, 1'b0);
    @(negedge clk);
    check("shadd_done", 32'(done), 32'd1);
    flags("shadd", 16'hC010, 0, 1, 0, 0);
    drive(3'b110, 16'h12AB, 16'h34CD, 1'b0, 1'b0);
    @(negedge clk); start = 1'b0;
    flags("cat", 16'hABCD, 0, 1, 0, 0);

    // Reset in the middle of a multiply
    drive(3'b111, 16'h0003, 16'h0005, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk); start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    flags("abort", 16'h0000, 0, 0, 0, 0);
    drive(3'b001, 16'hFFFF, 16'h0000, 1'b0, 1'b0);
    @(negedge clk); start = 1'b0;
    check("inc_done", 32'(done), 32'd1);
    flags("inc", 16'h0000, 1, 0, 1, 0);
    repeat (W + 2) begin
      @(negedge clk);
      check("abort_no_done", 32'(done), 32'd0);
    end

    // Negate corners
    drive(3'b000, 16'h8000, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    flags("neg_min", 16'h8000, 0, 1, 0, 1);
    drive(3'b000, 16'h0000, 16'h0000, 1'b0, 1'b0);
    @(negedge clk); start = 1'b0;
    flags("neg_zero", 16'h0000, 1, 0, 1, 0);

    // Model-only sweep of the remaining opcodes
    drive(3'b100, 16'hF0F0, 16'h3C3C, 1'b0, 1'b0);
    @(negedge clk);
    drive(3'b101, 16'hF0F0, 16'h0F0F, 1'b0, 1'b0);
    @(negedge clk);
    drive(3'b010, 16'h8000, 16'h8000, 1'b1, 1'b0);
    @(negedge clk);
    drive(3'b011, 16'h7FFF, 16'h7FFE, 1'b0, 1'b0);
    @(negedge clk);
    drive(3'b111, 16'h0000, 16'h1234, 1'b0, 1'b0);
    @(negedge clk); start = 1'b0;
    repeat (W + 2) @(negedge clk);
    check("mul_zero_zer", 32'(zer), 32'd1);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, registered successor to the team's 16-bit combinational ALU. It keeps the eight-entry opcode map and adds:
- a WIDTH parameter;
- a start/busy/done handshake;
- registered zero, negative, carry and overflow flags;
- carry chaining for multi-word adds;
- an iterative shift-add multiply on the previously unused opcode 111.

It sits between the datapath register file and the controller, which sequences operations through the handshake.

## Interface
- WIDTH, 16, operand/result width; must be even and ≥ 4. HALF = WIDTH/2 (derived, not overridable).
- clk  in  1  rising-edge clock. Single clock domain.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled on clk edges.
- opc  in  3  opcode.
- ina  in  WIDTH  signed operand A.
- inb  in  WIDTH  signed operand B.
- inc  in  1  external carry-in for opcode 010.
- usec  in  1  1 selects the stored cry flag as carry-in for opc 010, instead of inc.
- busy  out  1  high while a multiply is in progress.
- done  out  1  one-cycle pulse: new w and flags valid.
- w  out  WIDTH  registered result.
- zer, neg, cry, ovf  out  1 each  registered flags.

## Operation
States: IDLE, MUL. busy = (state == MUL).

Accept:
- An operation is accepted on an edge where start=1 and state=IDLE.
- start in MUL is ignored, with no queueing.
- Operands need not be held after the accept edge.

Single-cycle ops (opc 000-110):
- Result is computed from the inputs at the accept edge.
- On that same edge, w and the flags are written and done<=1. State stays IDLE.

Opcode definitions (all sums are modulo 2^WIDTH; cry is the unsigned carry-out; ovf is signed overflow):
- 000: w = -ina. cry = (ina==0). ovf = (ina==100…0).
- 001: w = ina+1. cry and ovf as defined for sums.
- 010: w = ina+inb+cin, where cin = usec ? cry : inc. cry and ovf from the WIDTH+1-bit sum.
- 011: w = ina + (inb>>>1), arithmetic shift. cry and ovf as for sums.
- 100: w = ina & inb. cry=0, ovf=0.
- 101: w = ina | inb. cry=0, ovf=0.
- 110: w = {ina[HALF-1:0], inb[HALF-1:0]}. cry=0, ovf=0.

Multiply (opc 111), low WIDTH bits of ina×inb:
- Accept edge: acc<=0, mcand<=ina, mplier<=inb, cnt<=WIDTH, state<=MUL. w and the flags are unchanged.
- Each MUL edge:
  - if mplier[0], acc += mcand;
  - mcand <<= 1; mplier >>= 1; cnt--.
- On the edge where cnt goes 1→0: w<=final acc, cry<=0, ovf<=0, done<=1, state<=IDLE.
- The low WIDTH bits are identical for signed and unsigned operands, so no sign correction is needed.

Flags:
- zer = (new w == 0). neg = new w[WIDTH-1].
- All four flags are written only on done edges and are held otherwise.

Between operations:
- w and the flags hold their last values.
- done is high exactly one cycle per operation.

## Timing
- Reset: on an edge with rst=1, all of the following go to 0 and state goes to IDLE:
  - w, zer, neg, cry, ovf, done, busy;
  - acc, mcand, mplier, cnt.
  - rst takes priority over start.
- Reset mid-multiply: the multiply is aborted, no done pulse is issued, and the block accepts on the first edge after rst is released.
- Single-cycle op latency: done and the result appear in the cycle immediately after the accept edge.
  - Back-to-back single-cycle ops every cycle are legal.
  - With usec=1, the op uses cry from the previous op even when that op completed on the preceding edge.
- Multiply latency: busy is high for WIDTH cycles after the accept edge. done and w appear in the cycle after the WIDTH-th MUL edge.
- First accept after multiply: on the edge ending the multiply, state is still MUL, so start is ignored. The earliest new accept is the following edge, i.e. the done cycle.
- Uncovered cases: none. All eight opcodes are defined, and no X outputs are permitted after reset.

## Test plan
All scenarios use WIDTH=16.
- Add overflow: rst 2 cycles, then start opc=010, ina=0x7FFF, inb=0x0001, inc=0, usec=0 → next cycle done=1, w=0x8000, neg=1, ovf=1, cry=0, zer=0. done=0 in the following cycle.
- 32-bit chained add:
  - opc=010, 0xFFFF + 0x0001, usec=0, inc=0 → w=0x0000, zer=1, cry=1.
  - Next cycle: opc=010, 0x0000 + 0x0000, usec=1 → w=0x0001, cry=0, zer=0.
- Signed multiply: opc=111, ina=0xFFFD (−3), inb=0x0007 → busy high 16 cycles, then done with w=0xFFEB, neg=1, cry=0, ovf=0. A start pulse at cycle 5 (opc=100) is ignored: w is unchanged until the multiply's done.
- Shift-add and concatenate:
  - opc=011, ina=0x0010, inb=0x8000 → w=0xC010, neg=1, cry=0.
  - opc=110, ina=0x12AB, inb=0x34CD → w=0xABCD, cry=0, ovf=0.
- Reset abort: rst asserted on the 5th MUL cycle → next cycle busy=0, w=0, all flags 0, and no done pulse. A following opc=001 with ina=0xFFFF gives w=0, zer=1, cry=1.
- Negate corners:
  - opc=000, ina=0x8000 → w=0x8000, ovf=1, neg=1.
  - opc=000, ina=0x0000 → w=0, zer=1, cry=1, ovf=0.
